// File: rtl/serdes_tx_gearbox_pipe.sv
`default_nettype none
// ============================================================================
// Module      : serdes_tx_gearbox_pipe
// Description : TX gearbox between the 128b/130b PCS encoder and the PHY.
//               Buffers encoded words in a small FIFO and emits OUT_W bits
//               per clock, MSB-first or LSB-first, with an idle pattern and
//               an underrun pulse when the word stream runs dry.
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_tx_gearbox_pipe #(
    parameter int              P_WIDTH   = 130,
    parameter int              OUT_W     = 10,
    parameter int              DEPTH     = 4,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [OUT_W-1:0] IDLE_PAT = 10'h155
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_en,
    input  logic [P_WIDTH-1:0]        in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_valid,
    output logic                      tx_busy,
    output logic                      underrun,
    output logic [$clog2(DEPTH):0]    fifo_level
);

    localparam int c_BEATS = P_WIDTH / OUT_W;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH) + 1;
    localparam int c_CNT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_BEATS - 1);
    localparam logic [c_LVL_W-1:0] c_FULL = c_LVL_W'(DEPTH);

    // Reject configurations the gearbox cannot serve at elaboration time
    generate
        if ((P_WIDTH % OUT_W) != 0) begin : g_bad_width
            $error("serdes_tx_gearbox_pipe: P_WIDTH must be a multiple of OUT_W");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("serdes_tx_gearbox_pipe: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [P_WIDTH-1:0]     r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_LVL_W-1:0]     r_level;
    logic [c_CNT_W-1:0]     r_beat_cnt;
    logic [P_WIDTH-1:0]     r_shift;
    logic [OUT_W-1:0]       r_out_data;
    logic                   r_out_valid;
    logic                   r_underrun;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_has_word;
    logic                   w_last;
    logic [OUT_W-1:0]       w_slice;
    logic [P_WIDTH-1:0]     w_shifted;

    // Readiness comes only from registered occupancy, so a same-cycle pop never frees a slot
    assign in_ready   = !rst && (r_level != c_FULL);
    assign w_push     = in_valid && in_ready;
    assign w_has_word = (r_level != '0);
    assign w_last     = (r_beat_cnt == c_LAST);
    assign w_slice    = MSB_FIRST ? r_shift[P_WIDTH-1 -: OUT_W] : r_shift[OUT_W-1:0];

    // Advance the shift register toward the emitting end; a single-beat word needs no shift
    generate
        if (c_BEATS > 1) begin : g_shift
            assign w_shifted = MSB_FIRST ? {r_shift[P_WIDTH-OUT_W-1:0], {OUT_W{1'b0}}}
                                         : {{OUT_W{1'b0}}, r_shift[P_WIDTH-1:OUT_W]};
        end else begin : g_no_shift
            assign w_shifted = '0;
        end
    endgenerate

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign underrun   = r_underrun;
    assign fifo_level = r_level;
    assign tx_busy    = (r_state == S_SHIFT) || w_has_word;

    // FIFO storage write; contents are don't-care until the write pointer covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and pop decision; a new word starts only with tx_en and a buffered word
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_en && w_has_word) begin
                    w_pop        = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    if (tx_en && w_has_word) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Gearbox datapath: load, emit one slice per cycle, flag underrun on the final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_beat_cnt  <= '0;
            r_out_data  <= IDLE_PAT;
            r_out_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_out_data  <= w_slice;
                    r_out_valid <= 1'b1;
                    r_underrun  <= w_last && tx_en && !w_has_word;
                    if (w_last) begin
                        r_beat_cnt <= '0;
                        r_shift    <= w_pop ? r_mem[r_rd_ptr] : w_shifted;
                    end else begin
                        r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                        r_shift    <= w_shifted;
                    end
                end
                default: begin
                    r_out_data  <= IDLE_PAT;
                    r_out_valid <= 1'b0;
                    r_underrun  <= 1'b0;
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_beat_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serdes_tx_gearbox_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_tx_gearbox_pipe
// Description : Directed self-checking bench for serdes_tx_gearbox_pipe,
//               covering MSB-first, LSB-first and full-width configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_tx_gearbox_pipe;

    localparam int PW = 130;
    localparam int OW = 10;
    localparam int NB = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default configuration (MSB first, 10-bit beats)
    logic          d_tx_en = 1'b0, d_in_valid = 1'b0;
    logic [PW-1:0] d_in_data = '0;
    logic          d_in_ready, d_out_valid, d_tx_busy, d_underrun;
    logic [OW-1:0] d_out_data;
    logic [2:0]    d_fifo_level;

    // LSB-first configuration
    logic          l_tx_en = 1'b0, l_in_valid = 1'b0;
    logic [PW-1:0] l_in_data = '0;
    logic          l_in_ready, l_out_valid, l_tx_busy, l_underrun;
    logic [OW-1:0] l_out_data;
    logic [2:0]    l_fifo_level;

    // Full-width configuration (one beat per word)
    logic          x_tx_en = 1'b0, x_in_valid = 1'b0;
    logic [PW-1:0] x_in_data = '0;
    logic          x_in_ready, x_out_valid, x_tx_busy, x_underrun;
    logic [PW-1:0] x_out_data;
    logic [2:0]    x_fifo_level;

    serdes_tx_gearbox_pipe u_dut (
        .clk(clk), .rst(rst), .tx_en(d_tx_en), .in_data(d_in_data), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .out_data(d_out_data), .out_valid(d_out_valid),
        .tx_busy(d_tx_busy), .underrun(d_underrun), .fifo_level(d_fifo_level)
    );

    serdes_tx_gearbox_pipe #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .tx_en(l_tx_en), .in_data(l_in_data), .in_valid(l_in_valid),
        .in_ready(l_in_ready), .out_data(l_out_data), .out_valid(l_out_valid),
        .tx_busy(l_tx_busy), .underrun(l_underrun), .fifo_level(l_fifo_level)
    );

    serdes_tx_gearbox_pipe #(.OUT_W(PW), .IDLE_PAT(130'h155)) u_wide (
        .clk(clk), .rst(rst), .tx_en(x_tx_en), .in_data(x_in_data), .in_valid(x_in_valid),
        .in_ready(x_in_ready), .out_data(x_out_data), .out_valid(x_out_valid),
        .tx_busy(x_tx_busy), .underrun(x_underrun), .fifo_level(x_fifo_level)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [PW-1:0] words [5];

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] msb_beat(input logic [PW-1:0] w, input int k);
        return w[PW-1-OW*k -: OW];
    endfunction

    function automatic logic [OW-1:0] lsb_beat(input logic [PW-1:0] w, input int k);
        return w[OW*k +: OW];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, beat, nunder, ngap, maxlvl;
        logic [PW-1:0] rebuilt;

        words[0] = 130'h2_DEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
        words[1] = 130'h1_0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
        words[2] = 130'h3_FEDC_BA98_7654_3210_0123_4567_89AB_CDEF;
        words[3] = 130'h0_AAAA_5555_CCCC_3333_F0F0_0F0F_1234_5678;
        words[4] = 130'h2_0000_0001_8000_0000_FFFF_FFFF_0000_0003;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_out_data",  d_out_data,   10'h155);
        check("rst_out_valid", d_out_valid,  1'b0);
        check("rst_underrun",  d_underrun,   1'b0);
        check("rst_tx_busy",   d_tx_busy,    1'b0);
        check("rst_level",     d_fifo_level, 3'd0);
        check("rst_in_ready",  d_in_ready,   1'b0);
        check("rst_wide_data", x_out_data,   130'h155);
        rst = 1'b0;
        tick();
        check("rel_in_ready",  d_in_ready,   1'b1);

        // Single word, MSB first
        d_tx_en = 1'b1; d_in_data = words[0]; d_in_valid = 1'b1;
        tick();
        d_in_valid = 1'b0;
        check("t1_level_e0", d_fifo_level, 3'd1);
        check("t1_valid_e0", d_out_valid,  1'b0);
        tick();
        check("t1_valid_e1", d_out_valid,  1'b0);
        check("t1_busy_e1",  d_tx_busy,    1'b1);
        check("t1_level_e1", d_fifo_level, 3'd0);
        for (int k = 0; k < NB; k++) begin
            tick();
            check("t1_valid", d_out_valid, 1'b1);
            check("t1_beat",  d_out_data,  msb_beat(words[0], k));
            check("t1_under", d_underrun,  (k == NB - 1));
        end
        tick();
        check("t1_end_valid", d_out_valid, 1'b0);
        check("t1_end_data",  d_out_data,  10'h155);
        check("t1_end_under", d_underrun,  1'b0);
        check("t1_end_busy",  d_tx_busy,   1'b0);

        // Single word, LSB first; beats must reassemble the word
        l_tx_en = 1'b1; l_in_data = words[0]; l_in_valid = 1'b1;
        tick();
        l_in_valid = 1'b0;
        tick();
        check("t2_valid_e1", l_out_valid, 1'b0);
        rebuilt = '0;
        for (int k = 0; k < NB; k++) begin
            tick();
            check("t2_valid", l_out_valid, 1'b1);
            check("t2_beat",  l_out_data,  lsb_beat(words[0], k));
            check("t2_under", l_underrun,  (k == NB - 1));
            rebuilt[OW*k +: OW] = l_out_data;
        end
        check("t2_first_beat", rebuilt[9:0],     10'h233);
        check("t2_last_beat",  rebuilt[129:120], 10'h2DE);
        check("t2_rebuilt",    rebuilt,          words[0]);
        tick();
        check("t2_end_valid", l_out_valid, 1'b0);
        check("t2_end_data",  l_out_data,  10'h155);

        // Full-width beats: three words back to back
        x_tx_en = 1'b1; x_in_valid = 1'b1; x_in_data = words[0];
        tick();
        x_in_data = words[1];
        tick();
        check("t6_valid_e1", x_out_valid, 1'b0);
        x_in_data = words[2];
        tick();
        x_in_valid = 1'b0;
        check("t6_valid_w0", x_out_valid, 1'b1);
        check("t6_data_w0",  x_out_data,  words[0]);
        check("t6_under_w0", x_underrun,  1'b0);
        tick();
        check("t6_valid_w1", x_out_valid, 1'b1);
        check("t6_data_w1",  x_out_data,  words[1]);
        check("t6_under_w1", x_underrun,  1'b0);
        tick();
        check("t6_valid_w2", x_out_valid, 1'b1);
        check("t6_data_w2",  x_out_data,  words[2]);
        check("t6_under_w2", x_underrun,  1'b1);
        tick();
        check("t6_end_valid", x_out_valid, 1'b0);
        check("t6_end_data",  x_out_data,  130'h155);
        check("t6_end_under", x_underrun,  1'b0);

        // Five words into a four-entry FIFO, continuous stream
        idx = 0; beat = 0; nunder = 0; ngap = 0; maxlvl = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (cyc > 0) begin
                if (d_out_valid) begin
                    if (beat < 5 * NB) check("t3_beat", d_out_data, msb_beat(words[beat / NB], beat % NB));
                    else check("t3_extra_beat", 1'b1, 1'b0);
                    beat++;
                end else if (beat > 0 && beat < 5 * NB) begin
                    ngap++;
                end
                if (d_underrun) nunder++;
                if (d_fifo_level == 3'd4) check("t3_full_ready", d_in_ready, 1'b0);
                if (int'(d_fifo_level) > maxlvl) maxlvl = int'(d_fifo_level);
            end
            if (idx < 5) begin
                d_in_valid = 1'b1;
                d_in_data  = words[idx];
                if (d_in_ready) idx++;
            end else begin
                d_in_valid = 1'b0;
            end
            tick();
        end
        check("t3_pushed",  idx,    5);
        check("t3_beats",   beat,   5 * NB);
        check("t3_gaps",    ngap,   0);
        check("t3_unders",  nunder, 1);
        check("t3_max_lvl", maxlvl, 4);

        // tx_en dropped mid-word with a second word queued
        d_tx_en = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        d_tx_en = 1'b1; d_in_valid = 1'b1; d_in_data = words[1];
        tick();
        d_in_data = words[2];
        tick();
        d_in_valid = 1'b0;
        beat = 0; nunder = 0;
        for (int t = 2; t <= 16; t++) begin
            tick();
            if (d_out_valid) begin
                if (beat < NB) check("t4_beat", d_out_data, msb_beat(words[1], beat));
                else check("t4_extra_beat", 1'b1, 1'b0);
                beat++;
            end
            if (d_underrun) nunder++;
            if (t == 7) d_tx_en = 1'b0;
        end
        check("t4_beats",  beat,         NB);
        check("t4_unders", nunder,       0);
        check("t4_valid",  d_out_valid,  1'b0);
        check("t4_level",  d_fifo_level, 3'd1);
        check("t4_busy",   d_tx_busy,    1'b1);
        d_tx_en = 1'b1;
        tick();
        check("t4_restart_gap",   d_out_valid,  1'b0);
        check("t4_restart_level", d_fifo_level, 3'd0);
        tick();
        check("t4_restart_valid", d_out_valid, 1'b1);
        check("t4_restart_beat",  d_out_data,  msb_beat(words[2], 0));

        // Reset mid-word with two words queued
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_tx_en = 1'b1; d_in_valid = 1'b1; d_in_data = words[3];
        tick();
        d_in_data = words[4];
        tick();
        d_in_data = words[0];
        tick();
        d_in_valid = 1'b0;
        for (int t = 3; t <= 9; t++) tick();
        check("t5_pre_valid", d_out_valid,  1'b1);
        check("t5_pre_beat",  d_out_data,   msb_beat(words[3], 7));
        check("t5_pre_level", d_fifo_level, 3'd2);
        rst = 1'b1;
        tick();
        check("t5_rst_valid", d_out_valid,  1'b0);
        check("t5_rst_data",  d_out_data,   10'h155);
        check("t5_rst_level", d_fifo_level, 3'd0);
        check("t5_rst_busy",  d_tx_busy,    1'b0);
        check("t5_rst_ready", d_in_ready,   1'b0);
        check("t5_rst_under", d_underrun,   1'b0);
        rst = 1'b0;
        tick();
        check("t5_rel_ready", d_in_ready,   1'b1);
        check("t5_rel_valid", d_out_valid,  1'b0);
        repeat (3) tick();
        check("t5_quiet_valid", d_out_valid,  1'b0);
        check("t5_quiet_level", d_fifo_level, 3'd0);
        check("t5_quiet_data",  d_out_data,   10'h155);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serdes_tx_gearbox_pipe.md
Name: serdes_tx_gearbox_pipe

Overview:
- Parametrised next-generation TX serializer between the 128b/130b PCS encoder and the PHY analog TX interface.
- Accepts encoded words over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Emits OUT_W bits per clock (gearbox), MSB-first or LSB-first.
- Drives an idle pattern and raises an underrun pulse when the word stream runs dry.

Parameters:
- P_WIDTH, 130: encoded input word width.
- OUT_W, 10: bits emitted per clock. P_WIDTH % OUT_W must be 0, else elaboration error. BEATS = P_WIDTH/OUT_W (13 at defaults).
- DEPTH, 4: input FIFO entries. Must be ≥2 and a power of 2, else elaboration error.
- MSB_FIRST, 1: 1 = word bit P_WIDTH-1 goes first; 0 = bit 0 goes first.
- IDLE_PAT, 10'h155: value driven on out_data when no word is being sent. Width OUT_W.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tx_en  in  1  permits starting a new word. Lowering it never truncates the word in flight.
- in_data  in  P_WIDTH  encoded word from PCS.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  OUT_W  serial beat to PHY (registered).
- out_valid  out  1  out_data carries word data (registered).
- tx_busy  out  1  FIFO non-empty or word in flight.
- underrun  out  1  one-cycle pulse: stream ended with FIFO empty while tx_en=1.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (rst high at posedge):
  - FIFO empty, pointers 0, fifo_level=0, state IDLE, beat_cnt=0.
  - out_data=IDLE_PAT, out_valid=0, underrun=0, tx_busy=0.
  - in_ready is forced 0 while rst=1.
- Reset mid-word: the word in flight and all FIFO contents are discarded. No partial beats after reset.
- Push:
  - Occurs on posedge when in_valid && in_ready.
  - in_ready = !rst && (fifo_level != DEPTH), combinational from registered occupancy.
  - No bypass: a pop in the same cycle does not open a slot when full.
- Pop: only from a registered non-empty FIFO. A word pushed at edge E is never popped at E.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves fifo_level unchanged.
- State IDLE:
  - out_valid<=0, out_data<=IDLE_PAT.
  - If tx_en && fifo_level>0: pop head into shift_reg, beat_cnt<=0, go to SHIFT.
- State SHIFT, each cycle:
  - out_data<=current slice: shift_reg[P_WIDTH-1 -: OUT_W] if MSB_FIRST, else shift_reg[OUT_W-1:0].
  - out_valid<=1, shift_reg shifts by OUT_W toward the emitting end, beat_cnt++.
- Last beat (beat_cnt==BEATS-1):
  - If tx_en && fifo_level>0: pop and load next word, beat_cnt<=0, stay in SHIFT. No gap beats.
  - Else go to IDLE.
  - If fifo_level==0 && tx_en: underrun<=1 for exactly one cycle (aligned with the last data beat on out_data).
  - tx_en=0 at the last beat: go to IDLE, no underrun.
- Latency: word accepted at edge E0 into an empty, idle block → beat 0 on out_data/out_valid after edge E0+2. The word occupies BEATS consecutive out_valid cycles.
- Throughput: sustained one word per BEATS cycles while the FIFO stays non-empty.
- tx_busy = (state==SHIFT) || (fifo_level!=0).
- beat_cnt width: $clog2(BEATS). Compare against BEATS-1 exactly; no wrap beyond it.
- OUT_W == P_WIDTH (BEATS=1) is legal: one word per cycle back-to-back, with the same 2-cycle latency.

Test Plan:
- Defaults, single word 130'h2_DEAD_BEEF_0123_4567_89AB_CDEF_0011_2233 pushed at E0 → out_valid high for 13 cycles starting after E0+2; first out_data = in_data[129:120]; then underrun pulses once; out_data returns to 10'h155.
- MSB_FIRST=0, same word → first beat = in_data[9:0], last beat = in_data[129:120]; concatenated beats reproduce the word exactly.
- Push 5 words back-to-back with DEPTH=4 and tx_en=1 → in_ready drops when fifo_level=4; 65 contiguous out_valid cycles with no gap; single underrun pulse at the end.
- tx_en dropped at beat 5 of word 1 with word 2 queued → word 1 completes all 13 beats; then out_valid=0, no underrun, fifo_level=1; raising tx_en starts word 2 two cycles later.
- rst asserted at beat 7 with 2 words queued → next cycle: out_valid=0, out_data=10'h155, fifo_level=0, tx_busy=0, in_ready=0 while rst is high, then 1 after rst is released.
- OUT_W=130 with 3 words pushed → 3 consecutive out_valid cycles, each out_data equal to the full word.
